// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cam_pkg
// Brief   : Shared types, RGB565 field positions and pixel conversion for
//           the OV7670 frame grabber.
// Revision: 1.0 - initial release
// ============================================================================
package cam_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2
    } cam_state_e;

    localparam int c_R_HI = 15;
    localparam int c_R_LO = 11;
    localparam int c_G_HI = 10;
    localparam int c_G_LO = 5;
    localparam int c_B_HI = 4;
    localparam int c_B_LO = 0;

    // Gray is 2R + G + B so each field carries roughly equal 6-bit weight.
    function automatic logic [8:0] rgb565_to_pix(input logic [15:0] pix16, input logic gray);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = pix16[c_R_HI:c_R_LO];
        g = pix16[c_G_HI:c_G_LO];
        b = pix16[c_B_HI:c_B_LO];
        if (gray) begin
            return {3'b000, r, 1'b0} + {3'b000, g} + {4'b0000, b};
        end
        return {r[4:2], g[5:3], b[4:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_bank_ram.sv
`default_nettype none
// ============================================================================
// Module  : cam_bank_ram
// Brief   : Two-bank pixel store; address MSB selects the bank.
// Revision: 1.0 - initial release
// ============================================================================
module cam_bank_ram #(
    parameter int DEPTH  = 8,
    parameter int PIX_W  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic [ADDR_W:0]   rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [PIX_W-1:0] mem_q [2][DEPTH];
    logic [PIX_W-1:0] rd_data_q;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic w_wr_in_range;
    logic w_rd_in_range;

    assign w_wr_idx      = wr_addr_i[c_IDX_W-1:0];
    assign w_rd_idx      = rd_addr_i[c_IDX_W-1:0];
    assign w_wr_in_range = ({1'b0, wr_addr_i[ADDR_W-1:0]} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr_i[ADDR_W-1:0]} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en_i && w_wr_in_range) begin
            mem_q[wr_addr_i[ADDR_W]][w_wr_idx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (w_rd_in_range) begin
            rd_data_q <= mem_q[rd_addr_i[ADDR_W]][w_rd_idx];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/cam_frame_grabber.sv
`default_nettype none
// ============================================================================
// Module  : cam_frame_grabber
// Brief   : OV7670 capture, decimation and colour conversion into a
//           double-buffered frame store with a registered read port.
// Revision: 1.0 - initial release
// ============================================================================
module cam_frame_grabber
    import cam_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DECIM  = 2,
    parameter int PIX_W  = 9,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              work_en,
    input  logic              gray_mode,
    input  logic [7:0]        cam_data,
    input  logic              ov_vs,
    input  logic              ov_hs,
    input  logic              ov_pclk,
    output logic              ov_rst,
    output logic              ov_pwdn,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              frame_valid,
    output logic [15:0]       frame_cnt,
    output logic              frame_err
);

    localparam int              c_DEPTH_I = (IMG_W >> DECIM) * (IMG_H >> DECIM);
    localparam int              c_COL_W   = $clog2(IMG_W + 1);
    localparam int              c_ROW_W   = $clog2(IMG_H + 1);
    localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W + 1)'(c_DEPTH_I);
    localparam logic [c_COL_W-1:0] c_COL_MAX  = c_COL_W'(IMG_W);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX  = c_ROW_W'(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_MASK = c_COL_W'((1 << DECIM) - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_MASK = c_ROW_W'((1 << DECIM) - 1);

    // Synchronisers: data, HREF and PCLK share identical depth to stay aligned.
    logic [1:0] pclk_sync_q, vs_sync_q, hs_sync_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       pclk_prev_q, vs_prev_q, hs_prev_q;

    cam_state_e state_q, state_d;
    logic [c_COL_W-1:0] col_q, col_d;
    logic [c_ROW_W-1:0] row_q, row_d;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic               gray_q, gray_d;
    logic               bank_q, bank_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic w_pclk_rise, w_vs_fall, w_vs_rise, w_hs_fall, w_keep, w_wr_en;
    logic [PIX_W-1:0] w_wr_data;

    assign w_pclk_rise = pclk_sync_q[1] & ~pclk_prev_q;
    assign w_vs_fall   = ~vs_sync_q[1] & vs_prev_q;
    assign w_vs_rise   = vs_sync_q[1] & ~vs_prev_q;
    assign w_hs_fall   = ~hs_sync_q[1] & hs_prev_q;
    assign w_keep      = ((col_q & c_COL_MASK) == '0) && ((row_q & c_ROW_MASK) == '0) &&
                         (col_q < c_COL_MAX) && (row_q < c_ROW_MAX);
    assign w_wr_data   = PIX_W'(rgb565_to_pix({hi_q, data_s2_q}, gray_q));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        wr_ptr_d = wr_ptr_q;
        gray_d   = gray_q;
        bank_d   = bank_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        w_wr_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (work_en) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!work_en) begin
                    state_d = S_IDLE;
                end else if (w_vs_fall) begin
                    state_d  = S_ACTIVE;
                    col_d    = '0;
                    row_d    = '0;
                    phase_d  = 1'b0;
                    wr_ptr_d = '0;
                    gray_d   = gray_mode;
                end
            end
            S_ACTIVE: begin
                if (!work_en) begin
                    state_d = S_IDLE;
                end else if (w_vs_rise) begin
                    // Any pixel edge coinciding with frame end is dropped.
                    state_d = S_WAIT;
                    if (wr_ptr_q == c_DEPTH) begin
                        bank_d  = ~bank_q;
                        cnt_d   = cnt_q + 16'd1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (w_hs_fall) begin
                    phase_d = 1'b0;
                    if (col_q != '0) begin
                        col_d = '0;
                        if (row_q != c_ROW_MAX) row_d = row_q + 1'b1;
                    end
                end else if (hs_sync_q[1] && w_pclk_rise) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = data_s2_q;
                    end else begin
                        if (w_keep) begin
                            if (wr_ptr_q == c_DEPTH) begin
                                err_d = 1'b1;
                            end else begin
                                w_wr_en  = 1'b1;
                                wr_ptr_d = wr_ptr_q + 1'b1;
                            end
                        end
                        if (col_q != c_COL_MAX) col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sync_q <= '0;
            vs_sync_q   <= '0;
            hs_sync_q   <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            pclk_prev_q <= 1'b0;
            vs_prev_q   <= 1'b0;
            hs_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            wr_ptr_q    <= '0;
            gray_q      <= 1'b0;
            bank_q      <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[0], ov_pclk};
            vs_sync_q   <= {vs_sync_q[0], ov_vs};
            hs_sync_q   <= {hs_sync_q[0], ov_hs};
            data_s1_q   <= cam_data;
            data_s2_q   <= data_s1_q;
            pclk_prev_q <= pclk_sync_q[1];
            vs_prev_q   <= vs_sync_q[1];
            hs_prev_q   <= hs_sync_q[1];
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            wr_ptr_q    <= wr_ptr_d;
            gray_q      <= gray_d;
            bank_q      <= bank_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Writes go to the hidden bank; reads use the bank as it stands this cycle.
    cam_bank_ram #(
        .DEPTH (c_DEPTH_I),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (w_wr_en),
        .wr_addr_i({~bank_q, wr_ptr_q[ADDR_W-1:0]}),
        .wr_data_i(w_wr_data),
        .rd_addr_i({bank_q, rd_addr}),
        .rd_data_o(rd_data)
    );

    assign ov_rst      = 1'b1;
    assign ov_pwdn     = 1'b0;
    assign frame_valid = valid_q;
    assign frame_cnt   = cnt_q;
    assign frame_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_grabber.sv
`default_nettype none
// ============================================================================
// Module  : tb_cam_frame_grabber
// Brief   : Randomised self-checking bench with a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cam_frame_grabber;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int DECIM  = 1;
    localparam int PIX_W  = 9;
    localparam int ADDR_W = 4;
    localparam int KW     = IMG_W >> DECIM;
    localparam int DEPTH  = KW * (IMG_H >> DECIM);

    logic              clk = 1'b0;
    logic              rst, work_en, gray_mode, ov_vs, ov_hs, ov_pclk;
    logic [7:0]        cam_data;
    logic              ov_rst, ov_pwdn, frame_valid, frame_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [15:0]       frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] frame_pix [IMG_H][IMG_W];
    int exp_disp [DEPTH];
    int exp_cnt  = 0;
    int exp_valid = 0;
    int exp_err  = 0;

    always #5 clk = ~clk;

    cam_frame_grabber #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DECIM(DECIM), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .work_en(work_en), .gray_mode(gray_mode),
        .cam_data(cam_data), .ov_vs(ov_vs), .ov_hs(ov_hs), .ov_pclk(ov_pclk),
        .ov_rst(ov_rst), .ov_pwdn(ov_pwdn), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int p, input int g);
        int r, gg, b;
        r  = (p / 2048) % 32;
        gg = (p / 32) % 64;
        b  = p % 32;
        if (g != 0) return 2 * r + gg + b;
        return (r / 4) * 64 + (gg / 8) * 8 + (b / 4);
    endfunction

    // One sensor PCLK period = 4 system clocks; bus changes while PCLK is low.
    task automatic pclk_cyc(input logic [7:0] d, input logic hs, input logic vs);
        @(negedge clk);
        cam_data = d; ov_hs = hs; ov_vs = vs; ov_pclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ov_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input int nlines, input int g, input int abort);
        int kept;
        gray_mode = g[0];
        repeat (3) pclk_cyc(8'h00, 1'b0, 1'b1);
        repeat (3) pclk_cyc(8'h00, 1'b0, 1'b0);
        gray_mode = 1'($urandom_range(0, 1));
        for (int r = 0; r < nlines; r++) begin
            if (abort != 0 && r == nlines / 2) begin
                @(negedge clk) work_en = 1'b0;
                repeat (4) @(negedge clk);
                work_en = 1'b1;
            end
            for (int c = 0; c < IMG_W; c++) begin
                pclk_cyc(frame_pix[r][c][15:8], 1'b1, 1'b0);
                pclk_cyc(frame_pix[r][c][7:0], 1'b1, 1'b0);
            end
            repeat (3) pclk_cyc(8'h00, 1'b0, 1'b0);
        end
        repeat (3) pclk_cyc(8'h00, 1'b0, 1'b1);
        if (abort == 0) begin
            kept = 0;
            for (int r = 0; r < nlines; r++)
                for (int c = 0; c < IMG_W; c++)
                    if (r % (1 << DECIM) == 0 && c % (1 << DECIM) == 0) kept++;
            if (kept == DEPTH) begin
                for (int i = 0; i < DEPTH; i++)
                    exp_disp[i] = ref_pix(frame_pix[(i / KW) << DECIM][(i % KW) << DECIM], g);
                exp_cnt   = (exp_cnt + 1) % 65536;
                exp_valid = 1;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic read_chk(input string tag, input int a, input int exp);
        @(negedge clk) rd_addr = ADDR_W'(a);
        @(posedge clk);
        #1 check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_valid"}, 32'(frame_valid), 32'(exp_valid));
        check({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        check({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        for (int i = 0; i < DEPTH; i++) read_chk($sformatf("%s_rd%0d", tag, i), i, exp_disp[i]);
        read_chk({tag, "_rd_oob"}, DEPTH, 0);
        read_chk({tag, "_rd_max"}, (1 << ADDR_W) - 1, 0);
    endtask

    task automatic fill(input int mode, input int v);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (mode)
                    0:       frame_pix[r][c] = 16'(v);
                    1:       frame_pix[r][c] = 16'(c + 16 * r);
                    default: frame_pix[r][c] = 16'($urandom);
                endcase
    endtask

    initial begin
        int nl, g;
        rst = 1'b1; work_en = 1'b0; gray_mode = 1'b0; cam_data = '0;
        ov_vs = 1'b0; ov_hs = 1'b0; ov_pclk = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_ov_rst", 32'(ov_rst), 1);
        check("rst_ov_pwdn", 32'(ov_pwdn), 0);
        @(negedge clk);
        rst = 1'b0;
        work_en = 1'b1;

        fill(0, 16'hF800); send_frame(IMG_H, 0, 0); check_frame("red");
        fill(0, 16'hFFFF); send_frame(IMG_H, 1, 0); check_frame("gray_white");
        fill(2, 0);        send_frame(2, 0, 0);     check_frame("short");
        fill(1, 0);        send_frame(IMG_H, 0, 0); check_frame("pattern");
        read_chk("pattern_c2r2", 5, ref_pix(2 + 16 * 2, 0));
        fill(2, 0);        send_frame(IMG_H, 1, 1); check_frame("abort");
        fill(2, 0);        send_frame(IMG_H, 1, 0); check_frame("after_abort");

        for (int k = 0; k < 10; k++) begin
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, IMG_H)) : IMG_H;
            g  = int'($urandom_range(0, 1));
            fill(2, 0);
            send_frame(nl, g, 0);
            check_frame($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_frame_grabber.md
Name: cam_frame_grabber

Overview:
- Parametrised OV7670 capture engine.
- Samples the camera bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain.
- Assembles RGB565 pixels, decimates by 2^DECIM in both axes, and converts each kept pixel to RGB333 or 9-bit gray.
- Writes into a double-banked frame buffer. The recognition/display logic reads only complete frames through a registered read port.

Parameters:
- IMG_W, 640, active pixels per line from the sensor
- IMG_H, 480, active lines per frame
- DECIM, 2, log2 decimation factor, applied horizontally and vertically
- PIX_W, 9, stored pixel width
- ADDR_W, 15, read address width; must satisfy 2^ADDR_W >= DEPTH, where DEPTH = (IMG_W>>DECIM)*(IMG_H>>DECIM)

Ports:
- clk  in  1  system clock; must run at >= 4x ov_pclk
- rst  in  1  reset, synchronous, active-high
- work_en  in  1  capture enable
- gray_mode  in  1  0 = RGB333, 1 = gray; latched at frame start
- cam_data  in  8  sensor data bus
- ov_vs  in  1  VSYNC, high during vertical blanking
- ov_hs  in  1  HREF, high during active line
- ov_pclk  in  1  sensor pixel clock, treated as data
- ov_rst  out  1  constant 1
- ov_pwdn  out  1  constant 0
- rd_addr  in  ADDR_W  read pixel index, row-major
- rd_data  out  PIX_W  pixel at rd_addr from display bank
- frame_valid  out  1  at least one complete frame published
- frame_cnt  out  16  published frame count, wraps
- frame_err  out  1  sticky: short frame or overflow seen

Behaviour:
- Reset (synchronous, active-high): all outputs, counters, FSM and bank select to 0, except ov_rst=1 and ov_pwdn=0. RAM contents are not cleared.
- Input sync: ov_pclk, ov_vs, ov_hs and cam_data pass through 2-FF synchronisers. Data stays aligned with the pclk sync path.
- pclk edge: pclk rising = sync_pclk & ~prev_pclk. All capture actions occur only on cycles with pclk rising.
- VS edges: vs_fall marks frame start; vs_rise marks frame end. Both are evaluated on synced VS every clk.
- FSM S_IDLE:
  - Enters S_WAIT when work_en=1.
- FSM S_WAIT:
  - On vs_fall, goes to S_ACTIVE.
  - On entry to S_ACTIVE: clears col, row, phase and wr_ptr, and latches gray_mode.
- FSM S_ACTIVE:
  - On vs_rise: publish check, then return to S_WAIT.
- work_en=0 in any state: go to S_IDLE next cycle. A partial frame is discarded; no bank swap.
- Byte assembly, in S_ACTIVE with HREF=1 on each pclk rising:
  - phase 0: store hi byte.
  - phase 1: complete pixel {hi, cam_data}, then col++.
  - phase toggles on every such edge.
- HREF falling: phase := 0. If col != 0, then row++ and col := 0.
- Keep rule: a pixel is kept iff col[DECIM-1:0]==0, row[DECIM-1:0]==0, col<IMG_W and row<IMG_H.
- Kept pixel handling:
  - Written to write bank at wr_ptr, then wr_ptr++.
  - If wr_ptr==DEPTH, the write is suppressed and frame_err is set.
- Conversion (RGB565 fields R=[15:11], G=[10:5], B=[4:0]):
  - RGB333 = {R[4:2], G[5:3], B[4:2]}.
  - gray = {R,1'b0} + G + B, zero-extended to 9 bits (max 156).
- Publish on vs_rise in S_ACTIVE:
  - If wr_ptr==DEPTH: toggle bank select, frame_cnt++, frame_valid := 1.
  - Otherwise: no swap and frame_err := 1.
- Banks: write bank = ~display bank. Reads never observe a partial frame.
- Read port:
  - rd_data is registered, 1-cycle latency.
  - rd_addr >= DEPTH yields 0.
  - Reads are from the display bank as selected on the cycle rd_addr is sampled.
  - A bank swap and a read in the same cycle: the read returns the old bank.
- Simultaneous vs_rise with pclk rising: the pixel is ignored; the publish check uses the wr_ptr value before that edge.

Decomposition:
- Package cam_pkg holds:
  - FSM state enum (S_IDLE, S_WAIT, S_ACTIVE)
  - RGB565 field index constants
  - conversion function rgb565_to_pix(pix16, gray) returning 9 bits
- Sub-module cam_bank_ram holds:
  - 2*DEPTH x PIX_W storage
  - one synchronous write port and one registered read port
  - bank bit as MSB of the address

Test Plan (IMG_W=8, IMG_H=4, DECIM=1, so DEPTH=8; clk = 4x pclk):
- Reset held 2 cycles -> rd_data=0, frame_valid=0, frame_cnt=0, frame_err=0, ov_rst=1, ov_pwdn=0.
- One full frame of pixel 0xF800, gray_mode=0 -> after vs_rise: frame_valid=1, frame_cnt=1; rd_addr 0..7 each return 9'h1C0 one cycle later.
- Same frame with pixel 0xFFFF, gray_mode=1 -> every rd_data = 156.
- Frame ending after 2 lines -> no swap, frame_cnt unchanged, frame_err=1; reads still return the previous frame's data.
- Pixel value = col + 16*row -> rd_addr 5 returns conversion of the pixel at (col 2, row 2); rd_addr 8 returns 0.
- work_en dropped mid-frame, then re-raised -> no publish for the aborted frame; the next full frame publishes with frame_cnt incremented by exactly 1.
